// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA pipeline: default pixel geometry and
// helpers for addressing pixels inside packed vectors.
package cfa_pkg;

    localparam int unsigned DefDataBitWidth = 12;
    localparam int unsigned DefBufferSize   = 5;

    // Ceiling log2, evaluated at elaboration time for counter widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        for (r = 0; (64'd1 << r) < 64'(v); r++) begin
        end
        return r;
    endfunction

    // Bit offset of pixel i in a packed vector (element 0 in the LSBs).
    function automatic int unsigned pix_offset(input int unsigned i, input int unsigned width);
        return i * width;
    endfunction

endpackage

// File: rtl/buffer1d_unload.sv
// Parallel-to-serial unloader: takes a packed vector of pixels in one cycle and
// streams them out element 0 first on a valid/ready interface.
module buffer1d_unload
    import cfa_pkg::*;
#(
    parameter int unsigned DataBitWidth = DefDataBitWidth,
    parameter int unsigned BufferSize   = DefBufferSize
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [BufferSize*DataBitWidth-1:0] d_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DataBitWidth-1:0]            d_out,
    output logic                               out_first,
    output logic                               out_last
);

    localparam int unsigned          CntW    = clog2(BufferSize + 1);
    localparam logic [CntW-1:0]      CntFull = CntW'(BufferSize);
    localparam logic [CntW-1:0]      CntOne  = CntW'(1);

    logic [DataBitWidth-1:0] mem_q [BufferSize];
    logic [DataBitWidth-1:0] mem_d [BufferSize];
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    vld_q, vld_d;
    logic                    out_fire, ld_fire;

    assign out_valid = vld_q & en;
    assign d_out     = mem_q[0];
    assign out_first = vld_q & (cnt_q == CntFull);
    assign out_last  = vld_q & (cnt_q == CntOne);
    assign out_fire  = out_valid & out_ready;
    // Accept a new vector as soon as the last pixel leaves, so there is no bubble.
    assign ld_ready  = en & ~rst & (~vld_q | (out_fire & out_last));
    assign ld_fire   = ld_valid & ld_ready;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        if (ld_fire) begin
            for (int unsigned i = 0; i < BufferSize; i++) begin
                mem_d[i] = d_in[pix_offset(i, DataBitWidth) +: DataBitWidth];
            end
            cnt_d = CntFull;
            vld_d = 1'b1;
        end else if (out_fire) begin
            for (int unsigned i = 0; i < BufferSize - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[BufferSize-1] = '0;
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
                vld_d = 1'b0;
            end
        end
    end

    // With en low neither handshake can fire, so the next state equals the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BufferSize; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

endmodule
